// File: rtl/add_stim_checker_if.sv
// Bus between the adder stimulus/checker and its environment: the operand
// pair going out to the adder under test, the result coming back, the sweep
// request and the sweep status/result registers.
interface add_stim_checker_if #(
   parameter int W = 4
);
   logic             start;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W:0]       sum;
   logic             busy;
   logic             done;
   logic             pass;
   logic [2*W:0]     err_cnt;
   logic [W-1:0]     first_err_a;
   logic [W-1:0]     first_err_b;

   // The checker drives operands and status, and receives start and sum
   modport master (
      input  start, sum,
      output a, b, busy, done, pass, err_cnt, first_err_a, first_err_b
   );

   // The environment drives start and the adder result, and observes the rest
   modport slave (
      output start, sum,
      input  a, b, busy, done, pass, err_cnt, first_err_a, first_err_b
   );
endinterface

// File: rtl/add_stim_checker.sv
// Exhaustive adder stimulus generator and checker. A sweep drives every
// operand pair {a,b} = 0 .. 2^(2W)-1 in order, predicts a+b for each pair and
// compares it against the adder result LATENCY+1 edges later, counting
// mismatches and capturing the operands of the first one.
module add_stim_checker #(
   parameter int W       = 4,
   parameter int LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   add_stim_checker_if.master   bus
);

   localparam int IW = 2 * W;
   localparam int EW = 2 * W + 1;
   localparam logic [2:0] DRAIN_LAST = 3'(LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [IW-1:0]   idx;
   logic [2:0]      drain_cnt;
   logic [EW-1:0]   err_cnt;
   logic [W-1:0]    first_err_a;
   logic [W-1:0]    first_err_b;

   logic [W:0]      exp_sum  [LATENCY+1];
   logic [IW-1:0]   exp_pair [LATENCY+1];
   logic [LATENCY:0] exp_valid;

   logic            start_ev;
   logic            last_pair;
   logic            issue;
   logic [IW-1:0]   pair_next;
   logic [W:0]      sum_next;
   logic            mismatch;

   // Decode the sweep events and the pair that goes out at the coming edge
   always_comb begin
      start_ev  = bus.start && ((state == IDLE) || (state == DONE));
      last_pair = (state == RUN) && (&idx);
      issue     = start_ev || ((state == RUN) && !(&idx));
      pair_next = start_ev ? '0 : idx + IW'(1);
      sum_next  = {1'b0, pair_next[IW-1:W]} + {1'b0, pair_next[W-1:0]};
      mismatch  = exp_valid[LATENCY] && (exp_sum[LATENCY] != bus.sum);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only honoured when no sweep is in flight
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ev)                    state_next = RUN;
         RUN:     if (last_pair)                   state_next = DRAIN;
         DRAIN:   if (drain_cnt == DRAIN_LAST)     state_next = DONE;
         DONE:    if (start_ev)                    state_next = RUN;
         default:                                  state_next = IDLE;
      endcase
   end

   // Status outputs decoded from the state alone so busy and done never overlap
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         RUN, DRAIN: bus.busy = 1'b1;
         DONE:       bus.done = 1'b1;
         default:    ;
      endcase
   end

   // Pair index; wrapping past the last pair leaves the operands at zero in DRAIN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (start_ev || (state == RUN)) begin
         idx <= pair_next;
      end
   end

   // Counts the cycles spent in DRAIN so the last pair's result gets compared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
      end else if (state != DRAIN) begin
         drain_cnt <= '0;
      end else begin
         drain_cnt <= drain_cnt + 3'(1);
      end
   end

   // Expected-value pipeline aligning each predicted sum with the adder output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_valid <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            exp_sum[i]  <= '0;
            exp_pair[i] <= '0;
         end
      end else begin
         exp_valid   <= {exp_valid[LATENCY-1:0], issue};
         exp_sum[0]  <= sum_next;
         exp_pair[0] <= pair_next;
         for (int i = 1; i <= LATENCY; i++) begin
            exp_sum[i]  <= exp_sum[i-1];
            exp_pair[i] <= exp_pair[i-1];
         end
      end
   end

   // Mismatch bookkeeping: saturating count, first failing operands kept per sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt     <= '0;
         first_err_a <= '0;
         first_err_b <= '0;
      end else if (start_ev) begin
         err_cnt     <= '0;
         first_err_a <= '0;
         first_err_b <= '0;
      end else if (mismatch) begin
         if (!(&err_cnt)) begin
            err_cnt <= err_cnt + EW'(1);
         end
         if (err_cnt == '0) begin
            first_err_a <= exp_pair[LATENCY][IW-1:W];
            first_err_b <= exp_pair[LATENCY][W-1:0];
         end
      end
   end

   assign bus.a           = idx[IW-1:W];
   assign bus.b           = idx[W-1:0];
   assign bus.err_cnt     = err_cnt;
   assign bus.first_err_a = first_err_a;
   assign bus.first_err_b = first_err_b;
   assign bus.pass        = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_add_stim_checker.sv
// Self-checking bench for add_stim_checker: a LATENCY=1 instance driven by a
// behavioural adder with selectable faults, and a LATENCY=2 instance driven
// by a correct two-stage adder.
module tb_add_stim_checker;

   logic clk = 1'b0;
   logic rst_n;
   int   mode;
   int   checks = 0;
   int   errors = 0;

   add_stim_checker_if #(.W(4)) bus1 ();
   add_stim_checker_if #(.W(4)) bus2 ();

   add_stim_checker #(.W(4), .LATENCY(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   add_stim_checker #(.W(4), .LATENCY(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   logic [4:0] s1_reg;
   logic [4:0] s1_pipe;
   logic [4:0] t1_reg;
   logic [4:0] t2_reg;

   // Adder models: registered adder (plus a second stage) and a two-stage adder
   always_ff @(posedge clk) begin
      s1_reg  <= {1'b0, bus1.a} + {1'b0, bus1.b};
      s1_pipe <= s1_reg;
      t1_reg  <= {1'b0, bus2.a} + {1'b0, bus2.b};
      t2_reg  <= t1_reg;
   end

   // Fault selection for the first adder: good, sum[4] stuck 0, all stuck 0, extra stage
   always_comb begin
      case (mode)
         0:       bus1.sum = s1_reg;
         1:       bus1.sum = {1'b0, s1_reg[3:0]};
         2:       bus1.sum = '0;
         default: bus1.sum = s1_pipe;
      endcase
   end

   assign bus2.sum = t2_reg;

   typedef struct {
      int mode;
      int exp_err;
      int exp_fa;
      int exp_fb;
      int exp_pass;
   } vec_t;

   vec_t vecs [3];

   // Compare one value and keep the running tallies
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive the start request of the first checker at the next falling edge
   task automatic applyStimulus(input logic start_val);
      @(negedge clk);
      bus1.start = start_val;
   endtask

   // Pulse start and follow the sweep, checking order and busy/done each cycle
   task automatic run_sweep(input int restart_at, output int k_done, output int seq_err);
      logic [7:0] exp_ab;
      k_done  = -1;
      seq_err = 0;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      for (int k = 0; k < 400; k++) begin
         exp_ab = (k < 256) ? 8'(k) : 8'd0;
         if ({bus1.a, bus1.b} != exp_ab) seq_err++;
         if (bus1.busy && bus1.done) seq_err++;
         if (bus1.done) begin
            k_done = k;
            break;
         end
         if (!bus1.busy) seq_err++;
         if (restart_at >= 0 && k == restart_at) bus1.start = 1'b1;
         if (restart_at >= 0 && k == restart_at + 3) bus1.start = 1'b0;
         @(negedge clk);
      end
      bus1.start = 1'b0;
   endtask

   // Wait for the first checker to report done, bounded
   task automatic wait_done(output int k_done);
      k_done = -1;
      for (int k = 0; k < 400; k++) begin
         if (bus1.done) begin
            k_done = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Bound the whole run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      int k_done;
      int seq_err;
      int found;

      vecs[0] = '{0, 0,   0, 0,  1};
      vecs[1] = '{1, 120, 1, 15, 0};
      vecs[2] = '{2, 255, 0, 1,  0};

      mode       = 0;
      rst_n      = 1'b0;
      bus1.start = 1'b0;
      bus2.start = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rst_a",        int'(bus1.a),           0);
      checkOutput("rst_b",        int'(bus1.b),           0);
      checkOutput("rst_busy",     int'(bus1.busy),        0);
      checkOutput("rst_done",     int'(bus1.done),        0);
      checkOutput("rst_pass",     int'(bus1.pass),        0);
      checkOutput("rst_err_cnt",  int'(bus1.err_cnt),     0);
      checkOutput("rst_first_a",  int'(bus1.first_err_a), 0);
      checkOutput("rst_first_b",  int'(bus1.first_err_b), 0);

      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("idle_wait_busy", int'(bus1.busy), 0);
      checkOutput("idle_wait_done", int'(bus1.done), 0);

      for (int i = 0; i < 3; i++) begin
         mode = vecs[i].mode;
         run_sweep(-1, k_done, seq_err);
         $display("[TB] sweep mode %0d finished", mode);
         checkOutput("vec_done_latency", k_done,                 258);
         checkOutput("vec_sweep_order",  seq_err,                0);
         checkOutput("vec_busy_low",     int'(bus1.busy),        0);
         checkOutput("vec_err_cnt",      int'(bus1.err_cnt),     vecs[i].exp_err);
         checkOutput("vec_first_a",      int'(bus1.first_err_a), vecs[i].exp_fa);
         checkOutput("vec_first_b",      int'(bus1.first_err_b), vecs[i].exp_fb);
         checkOutput("vec_pass",         int'(bus1.pass),        vecs[i].exp_pass);
      end

      mode = 0;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("restart_err_cleared", int'(bus1.err_cnt),     0);
      checkOutput("restart_first_a",     int'(bus1.first_err_a), 0);
      checkOutput("restart_first_b",     int'(bus1.first_err_b), 0);
      checkOutput("restart_busy",        int'(bus1.busy),        1);
      checkOutput("restart_done_low",    int'(bus1.done),        0);
      checkOutput("restart_pair0",       int'({bus1.a, bus1.b}), 0);
      wait_done(k_done);
      checkOutput("restart_done_seen",   int'(bus1.done),        1);
      checkOutput("restart_pass",        int'(bus1.pass),        1);

      run_sweep(50, k_done, seq_err);
      checkOutput("ignore_start_latency", k_done,             258);
      checkOutput("ignore_start_order",   seq_err,            0);
      checkOutput("ignore_start_pass",    int'(bus1.pass),    1);

      mode = 3;
      run_sweep(-1, k_done, seq_err);
      checkOutput("lat_mismatch_done",        k_done,                      258);
      checkOutput("lat_mismatch_err_nonzero", int'(bus1.err_cnt != 9'd0),  1);
      checkOutput("lat_mismatch_pass",        int'(bus1.pass),             0);

      mode = 1;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      found = 0;
      for (int k = 0; k < 300; k++) begin
         if ({bus1.a, bus1.b} == 8'd100) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reach_idx100", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_a",       int'(bus1.a),           0);
      checkOutput("midrst_b",       int'(bus1.b),           0);
      checkOutput("midrst_busy",    int'(bus1.busy),        0);
      checkOutput("midrst_done",    int'(bus1.done),        0);
      checkOutput("midrst_err_cnt", int'(bus1.err_cnt),     0);
      checkOutput("midrst_first_a", int'(bus1.first_err_a), 0);
      checkOutput("midrst_first_b", int'(bus1.first_err_b), 0);
      @(negedge clk);
      mode  = 0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("midrst_idle_busy", int'(bus1.busy), 0);
      checkOutput("midrst_idle_err",  int'(bus1.err_cnt), 0);
      run_sweep(-1, k_done, seq_err);
      checkOutput("midrst_sweep_latency", k_done,             258);
      checkOutput("midrst_sweep_order",   seq_err,            0);
      checkOutput("midrst_sweep_err",     int'(bus1.err_cnt), 0);
      checkOutput("midrst_sweep_pass",    int'(bus1.pass),    1);

      @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      k_done = -1;
      for (int k = 0; k < 400; k++) begin
         if (bus2.done) begin
            k_done = k;
            break;
         end
         @(negedge clk);
      end
      checkOutput("lat2_done_latency", k_done,             259);
      checkOutput("lat2_err_cnt",      int'(bus2.err_cnt), 0);
      checkOutput("lat2_pass",         int'(bus2.pass),    1);

      @(negedge clk);
      rst_n      = 1'b0;
      bus1.start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("start_at_release_busy",  int'(bus1.busy),        1);
      checkOutput("start_at_release_pair0", int'({bus1.a, bus1.b}), 0);
      bus1.start = 1'b0;
      wait_done(k_done);
      checkOutput("start_at_release_done", int'(bus1.done), 1);
      checkOutput("start_at_release_pass", int'(bus1.pass), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/add_stim_checker.md
ADD_STIM_CHECKER -- requirements
Module: add_stim_checker

Interface
REQ-001 Parameter W, default 4, operand width; sum width is W+1.
REQ-002 Parameter LATENCY, default 1, adder clock latency in cycles; legal 1..4.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level-sampled request to begin a sweep.
REQ-006 a  output  W  operand A driven to adder, registered.
REQ-007 b  output  W  operand B driven to adder, registered.
REQ-008 sum  input  W+1  adder result, sampled on rising edge.
REQ-009 busy  output  1  high while a sweep or its drain is in progress.
REQ-010 done  output  1  high when a sweep has completed.
REQ-011 pass  output  1  high when done=1 and err_cnt=0.
REQ-012 err_cnt  output  2W+1  number of mismatches in the current or last sweep.
REQ-013 first_err_a  output  W  operand A of the first mismatching pair.
REQ-014 first_err_b  output  W  operand B of the first mismatching pair.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 sampled at edge s -> RUN; pair index idx=0 is driven after edge s.
REQ-017 RUN: {a,b}=idx, a the high half; idx increments by 1 each edge, covering 0..2^(2W)-1 exactly once, in order.
REQ-018 RUN -> DRAIN on the edge after idx=2^(2W)-1 is driven; a,b return to 0 in DRAIN.
REQ-019 DRAIN lasts LATENCY+1 cycles, then -> DONE.
REQ-020 DONE: done=1 held; start=1 -> RUN with a full restart (counters and capture registers cleared, idx=0).
REQ-021 A pair driven after edge t SHALL be compared against sum sampled at edge t+LATENCY+1; a valid-tagged expected-value pipeline of LATENCY+1 stages holds a+b, zero-extended to W+1 bits.
REQ-022 Mismatch: err_cnt increments, saturating at 2^(2W+1)-1; never wraps.
REQ-023 first_err_a/first_err_b load only on the first mismatch of a sweep; they hold until the next start.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 busy=1 in RUN and DRAIN only; done=1 in DONE only; busy and done are never both 1.
REQ-026 For W=4, LATENCY=1: start at edge s -> done rises after edge s+258; no compare occurs after done.
REQ-027 Outputs not covered above hold their value; sum is ignored outside valid compare slots.

Reset
REQ-028 rst_n=0 SHALL, asynchronously, force state IDLE and set a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, first_err_a=0, first_err_b=0, idx=0, and all pipeline valid bits 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep without a residual compare; after release, the block waits in IDLE for start.
REQ-030 start held high during reset release SHALL begin a sweep at the first edge with rst_n=1.

Verification
REQ-031 Correct registered adder (LATENCY=1), start pulse -> a/b sweep 0/0..15/15, done=1, pass=1, err_cnt=0 after 258 cycles.
REQ-032 Adder with sum[4] stuck at 0 -> err_cnt=120, first_err_a=1, first_err_b=15, pass=0.
REQ-033 Adder with sum stuck at 0 -> err_cnt=255, first_err_a=0, first_err_b=1.
REQ-034 Two-stage adder with LATENCY=2 -> pass=1. The same adder with LATENCY=1 -> err_cnt>0.
REQ-035 rst_n pulsed low at idx=100 -> all outputs 0 immediately; a subsequent start runs a full clean sweep and reaches pass=1.
REQ-036 start re-asserted at idx=50 -> ignored, sweep unaffected. start in DONE -> err_cnt cleared and a new sweep begins.
